// File: rtl/alu_pkg.sv
// ALU op-code encodings and datapath widths shared by the ALU and the ALU arbiter.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 6;

    localparam logic [CTRL_W-1:0] ADD  = 6'd0;
    localparam logic [CTRL_W-1:0] SUB  = 6'd1;
    localparam logic [CTRL_W-1:0] XOR  = 6'd2;
    localparam logic [CTRL_W-1:0] SLL  = 6'd3;
    localparam logic [CTRL_W-1:0] SLT  = 6'd4;
    localparam logic [CTRL_W-1:0] SRL  = 6'd5;
    localparam logic [CTRL_W-1:0] SRA  = 6'd6;
    localparam logic [CTRL_W-1:0] AND  = 6'd7;
    localparam logic [CTRL_W-1:0] OR   = 6'd8;
    localparam logic [CTRL_W-1:0] BEQ  = 6'd9;
    localparam logic [CTRL_W-1:0] BNE  = 6'd10;
    localparam logic [CTRL_W-1:0] BLT  = 6'd11;
    localparam logic [CTRL_W-1:0] BGE  = 6'd12;
    localparam logic [CTRL_W-1:0] SLTU = 6'd13;
    localparam logic [CTRL_W-1:0] BLTU = 6'd14;
    localparam logic [CTRL_W-1:0] BGEU = 6'd15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: priority starts one past rr_last and wraps modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_last,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    always_comb begin
        grant    = '0;
        grant_id = '0;
        // Scan from lowest to highest priority so the highest-priority hit is the last write.
        for (int unsigned off = NREQ; off >= 1; off--) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req[i] && (i == (32'(rr_last) + off) % NREQ)) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    grant_id = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters through a two-stage
// operand/result pipeline with round-robin grant and per-requester valid/ready.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned CTRL_W = alu_pkg::CTRL_W,
    parameter int unsigned ID_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_srca,
    input  logic [NREQ*DATA_W-1:0] req_srcb,
    input  logic [NREQ*CTRL_W-1:0] req_ctrl,
    input  logic                   flush,
    output logic [DATA_W-1:0]      alu_srca,
    output logic [DATA_W-1:0]      alu_srcb,
    output logic [CTRL_W-1:0]      alu_ctrl,
    input  logic [DATA_W-1:0]      alu_out,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   busy
);

    logic              s1_v_q, s1_v_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic [DATA_W-1:0] srca_q, srca_d;
    logic [DATA_W-1:0] srcb_q, srcb_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              s2_v_q, s2_v_d;
    logic [ID_W-1:0]   s2_id_q, s2_id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   rr_last_q, rr_last_d;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_id;
    logic [DATA_W-1:0] sel_srca, sel_srcb;
    logic [CTRL_W-1:0] sel_ctrl;
    logic              rsp_fire, s2_adv, s1_free, accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .rr_last  (rr_last_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        sel_srca  = '0;
        sel_srcb  = '0;
        sel_ctrl  = '0;
        rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_srca = req_srca[i*DATA_W +: DATA_W];
                sel_srcb = req_srcb[i*DATA_W +: DATA_W];
                sel_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
            end
            rsp_valid[i] = s2_v_q && (32'(s2_id_q) == i);
        end
    end

    assign rsp_fire  = |(rsp_valid & rsp_ready);
    assign s2_adv    = s1_v_q & (~s2_v_q | rsp_fire);
    assign s1_free   = ~s1_v_q | s2_adv;
    assign req_ready = grant & {NREQ{s1_free & ~flush}};
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_id_d   = s1_id_q;
        srca_d    = srca_q;
        srcb_d    = srcb_q;
        ctrl_d    = ctrl_q;
        s2_v_d    = s2_v_q;
        s2_id_d   = s2_id_q;
        data_d    = data_q;
        rr_last_d = rr_last_q;
        if (flush) begin
            // A response firing this cycle is already delivered; everything else is dropped.
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else begin
            if (accept) begin
                s1_v_d    = 1'b1;
                s1_id_d   = grant_id;
                srca_d    = sel_srca;
                srcb_d    = sel_srcb;
                ctrl_d    = sel_ctrl;
                rr_last_d = grant_id;
            end else if (s2_adv) begin
                s1_v_d = 1'b0;
            end
            if (s2_adv) begin
                s2_v_d  = 1'b1;
                s2_id_d = s1_id_q;
                data_d  = alu_out;
            end else if (rsp_fire) begin
                s2_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_id_q   <= '0;
            srca_q    <= '0;
            srcb_q    <= '0;
            ctrl_q    <= CTRL_W'(ADD);
            s2_v_q    <= 1'b0;
            s2_id_q   <= '0;
            data_q    <= '0;
            rr_last_q <= ID_W'(NREQ - 1);
        end else begin
            s1_v_q    <= s1_v_d;
            s1_id_q   <= s1_id_d;
            srca_q    <= srca_d;
            srcb_q    <= srcb_d;
            ctrl_q    <= ctrl_d;
            s2_v_q    <= s2_v_d;
            s2_id_q   <= s2_id_d;
            data_q    <= data_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign alu_srca = srca_q;
    assign alu_srcb = srcb_q;
    assign alu_ctrl = ctrl_q;
    assign rsp_data = data_q;
    assign busy     = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with three requesters: directed scenarios, then random
// traffic against a queue-based model of a two-entry in-order pipeline.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int CW   = 6;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*DW-1:0]   req_srca, req_srcb;
    logic [NREQ*CW-1:0]   req_ctrl;
    logic                 flush, busy;
    logic [DW-1:0]        alu_srca, alu_srcb, alu_out, rsp_data;
    logic [CW-1:0]        alu_ctrl;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DW),
        .CTRL_W (CW),
        .ID_W   (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_srca  (req_srca),
        .req_srcb  (req_srcb),
        .req_ctrl  (req_ctrl),
        .flush     (flush),
        .alu_srca  (alu_srca),
        .alu_srcb  (alu_srcb),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [5:0] c);
        case (c)
            ADD:     return a + b;
            SUB:     return a - b;
            XOR:     return a ^ b;
            SLL:     return a << b[4:0];
            SLT:     return {31'b0, $signed(a) < $signed(b)};
            SRL:     return a >> b[4:0];
            SRA:     return $unsigned($signed(a) >>> b[4:0]);
            AND:     return a & b;
            OR:      return a | b;
            BEQ:     return {31'b0, a == b};
            BNE:     return {31'b0, a != b};
            BLT:     return {31'b0, $signed(a) < $signed(b)};
            BGE:     return {31'b0, $signed(a) >= $signed(b)};
            SLTU:    return {31'b0, a < b};
            BLTU:    return {31'b0, a < b};
            BGEU:    return {31'b0, a >= b};
            default: return 32'h0;
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_srca, alu_srcb, alu_ctrl);

    typedef struct {
        int          id;
        logic [31:0] data;
        int          vis;
    } ent_t;

    ent_t mq[$];    // model pipeline contents, oldest first
    ent_t sb_q[$];  // expected responses awaiting the monitor
    int   rr_m   = NREQ - 1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(int i);
        logic [NREQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] v, int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_valid();
        if (mq.size() > 0 && mq[0].vis <= cyc) return onehot(mq[0].id);
        return '0;
    endfunction

    // Two-entry pipe: a new op fits unless both slots are full and the head does not leave.
    function automatic logic [NREQ-1:0] exp_ready();
        bit free;
        int g;
        free = (mq.size() < 2) || (|(exp_valid() & rsp_ready));
        g    = rr_pick(req_valid, rr_m);
        if (g < 0 || !free || flush) return '0;
        return onehot(g);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            sb_q.delete();
            rr_m = NREQ - 1;
        end else begin
            logic [NREQ-1:0] rdy;
            bit              fire;
            int              g;
            ent_t            e;
            rdy  = exp_ready();
            fire = |(exp_valid() & rsp_ready);
            if (fire) begin
                mq.delete(0);
                if (mq.size() > 0 && mq[0].vis < cyc + 1) mq[0].vis = cyc + 1;
            end
            if (flush) begin
                mq.delete();
                sb_q.delete();
            end else if (|(req_valid & rdy)) begin
                g      = rr_pick(req_valid, rr_m);
                e.id   = g;
                e.data = alu_fn(req_srca[g*DW +: DW], req_srcb[g*DW +: DW], req_ctrl[g*CW +: CW]);
                e.vis  = cyc + 2;
                mq.push_back(e);
                sb_q.push_back(e);
                rr_m = g;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("req_ready", 64'(req_ready), 64'(exp_ready()));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_valid()));
            check("busy", 64'(busy), 64'(mq.size() > 0));
            if (rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    check("rsp_id", 64'(rsp_valid), 64'(onehot(sb_q[0].id)));
                    check("rsp_data", 64'(rsp_data), 64'(sb_q[0].data));
                    if (|(rsp_valid & rsp_ready)) sb_q.delete(0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] c);
        req_srca[i*DW +: DW] = a;
        req_srcb[i*DW +: DW] = b;
        req_ctrl[i*CW +: CW] = c;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        flush     = 1'b0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_alu_srca", 64'(alu_srca), 64'(0));
        check("rst_alu_srcb", 64'(alu_srcb), 64'(0));
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
    endtask

    logic [NREQ-1:0] pending;
    logic [DW-1:0]   hold_a, hold_d;
    int              accepts;

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; flush = 1'b0;
        req_srca = '0; req_srcb = '0; req_ctrl = '0;

        // Reset values, then a single ADD with two-cycle latency.
        do_reset();
        @(negedge clk);
        check_reset_outputs();
        tick();
        set_req(0, 32'd5, 32'd7, ADD);
        req_valid = 3'b001;
        rsp_ready = '1;
        @(negedge clk);
        check("add_ready", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("add_valid", 64'(rsp_valid), 64'(3'b001));
        check("add_data", 64'(rsp_data), 64'(12));
        tick();
        @(negedge clk);
        check("add_idle", 64'(busy), 64'(0));

        // Two requesters every cycle: grants and results alternate.
        do_reset();
        set_req(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, XOR);
        set_req(1, 32'h1, 32'h2, OR);
        rsp_ready = '1;
        for (int k = 0; k < 8; k++) begin
            tick();
            req_valid = 3'b011;
            @(negedge clk);
            check("alt_grant", 64'(req_ready), 64'((k % 2) != 0 ? 3'b010 : 3'b001));
            if (k >= 2) begin
                check("alt_rsp_id", 64'(rsp_valid), 64'((k % 2) != 0 ? 3'b010 : 3'b001));
                check("alt_rsp_data", 64'(rsp_data),
                      64'((k % 2) != 0 ? 32'h3 : 32'hFFFF_FFFF));
            end
        end
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Backpressure: three queued requests, only two fit while responses stall.
        do_reset();
        set_req(0, 32'd100, 32'd1, SUB);
        set_req(1, 32'h8000_0000, 32'd4, SRA);
        set_req(2, 32'd3, 32'd9, SLTU);
        pending = 3'b111;
        accepts = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            req_valid = pending;
            @(negedge clk);
            accepts += $countones(req_valid & req_ready);
            pending &= ~req_ready;
            if (k == 2) begin
                hold_a = alu_srca;
                hold_d = rsp_data;
            end
        end
        check("bp_accepts", 64'(accepts), 64'(2));
        check("bp_ready_zero", 64'(req_ready), 64'(0));
        check("bp_alu_stable", 64'(alu_srca), 64'(hold_a));
        check("bp_data_stable", 64'(rsp_data), 64'(hold_d));
        for (int k = 0; k < 6; k++) begin
            tick();
            rsp_ready = '1;
            req_valid = pending;
            @(negedge clk);
            pending &= ~req_ready;
        end
        check("bp_all_accepted", 64'(pending), 64'(0));
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Flush with both stages full, then a fresh op completes normally.
        do_reset();
        tick();
        set_req(0, 32'd1, 32'd2, ADD);
        req_valid = 3'b001;
        tick();
        set_req(1, 32'd9, 32'd4, SUB);
        req_valid = 3'b010;
        tick();
        flush     = 1'b1;
        req_valid = 3'b100;
        @(negedge clk);
        check("flush_no_accept", 64'(req_ready), 64'(0));
        check("flush_busy", 64'(busy), 64'(1));
        tick();
        flush     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("flush_rsp_gone", 64'(rsp_valid), 64'(0));
        check("flush_idle", 64'(busy), 64'(0));
        tick();
        set_req(2, 32'hAAAA_0000, 32'h0000_AAAA, XOR);
        req_valid = 3'b100;
        rsp_ready = '1;
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("post_flush_valid", 64'(rsp_valid), 64'(3'b100));
        check("post_flush_data", 64'(rsp_data), 64'(32'hAAAA_AAAA));
        repeat (4) tick();

        // Reset while requester 1 holds a pending response.
        do_reset();
        tick();
        set_req(1, 32'hFF, 32'h0F, AND);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("midrst_pending", 64'(rsp_valid), 64'(3'b010));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        tick();
        set_req(0, 32'd2, 32'd3, SLL);
        req_valid = 3'b011;
        rsp_ready = '1;
        @(negedge clk);
        check("midrst_first_grant", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Random traffic including out-of-range ctrl codes, flushes and resets.
        for (int k = 0; k < 800; k++) begin
            tick();
            rst_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                        6'($urandom_range(0, 17)));
            end
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom | (($urandom_range(0, 3) == 0) ? 32'h7 : 32'h0));
            flush     = ($urandom_range(0, 31) == 0);
        end

        tick();
        rst_n     = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        rsp_ready = '1;
        repeat (5) tick();
        @(negedge clk);
        check("drain_scoreboard", 64'(sb_q.size()), 64'(0));
        check("drain_busy", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit ALU between NREQ requesters, e.g. the execute stage and the address/branch-compare unit.
- Two-stage pipeline: round-robin grant into an operand register that drives the ALU, then a result register returned to the owning requester over valid/ready.
- Instantiated beside the ALU in the execute stage. The ALU itself is unchanged and stays purely combinational.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DATA_W, 32, operand/result width.
- CTRL_W, 6, ALU control code width.
- ID_W, 2, requester index width; must be at least clog2(NREQ).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; may depend on req_valid.
- req_srca  in  NREQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W].
- req_srcb  in  NREQ*DATA_W  operand B, same packing as req_srca.
- req_ctrl  in  NREQ*CTRL_W  ALU op code, requester i at [i*CTRL_W +: CTRL_W].
- flush  in  1  kill every in-flight op (pipeline redirect).
- alu_srca  out  DATA_W  to ALU srca.
- alu_srcb  out  DATA_W  to ALU srcb.
- alu_ctrl  out  CTRL_W  to ALU control.
- alu_out  in  DATA_W  from ALU result (combinational).
- rsp_valid  out  NREQ  one-hot; result for requester i.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_data  out  DATA_W  result, shared by all requesters.
- busy  out  1  high when s1_v or s2_v is set.

Behaviour:
- State:
  - S1 operand register: s1_v, s1_id, srca, srcb, ctrl; its fields drive alu_* directly.
  - S2 result register: s2_v, s2_id, data.
  - RR pointer: rr_last (ID_W bits).
- Reset (rst_n=0 at an edge):
  - s1_v=0, s2_v=0, rr_last=NREQ-1, so requester 0 has first priority.
  - S1 data fields clear to 0, giving alu_srca/alu_srcb=0 and alu_ctrl=0 (ADD).
  - rsp_valid=0, rsp_data=0, busy=0, req_ready=0.
  - Reset mid-operation discards all in-flight ops; no response is produced.
- Handshake definitions:
  - rsp_fire = |(rsp_valid & rsp_ready).
  - s2_adv = s1_v & (~s2_v | rsp_fire).
  - s1_free = ~s1_v | s2_adv.
- Arbitration:
  - Priority starts at index rr_last+1 and wraps modulo NREQ; the highest-priority requester with req_valid set is granted.
  - Grant is exclusive and computed combinationally each cycle.
  - req_ready[i] = grant[i] & s1_free & ~flush.
- On accept (req_valid[g] & req_ready[g]): S1 loads operands, ctrl and id=g; s1_v=1; rr_last=g.
- rr_last changes only on an accept, never on a request that is not accepted.
- Advance and retire:
  - On s2_adv: S2 captures alu_out, id=s1_id; s2_v=1.
  - If no new accept in the same cycle, s1_v clears.
  - On rsp_fire without an incoming s2_adv, s2_v clears.
  - Simultaneous retire and advance is allowed: S2 is overwritten and stays valid.
  - A simultaneous accept into S1 is allowed in that same cycle.
- Outputs:
  - rsp_valid[i] = s2_v & (s2_id==i).
  - rsp_data = S2 data, held stable while rsp_valid is high and not fired.
- Latency and throughput:
  - Accept at cycle N gives rsp_valid at N+2.
  - Back-to-back throughput is 1 op/cycle when rsp_ready stays high.
- Backpressure: if S2 is stalled, S1 holds with alu_* stable, and once S1 is full req_ready is all-zero.
- Flush:
  - Clears s1_v and s2_v at the edge; rsp_valid drops the next cycle.
  - No accept occurs in a flush cycle.
  - rr_last is kept.
  - A rsp_fire in the same cycle as flush counts as delivered.
- Width rules:
  - Operands pass unmodified.
  - ctrl values above 15 are forwarded as-is; ALU default behaviour applies.
  - No ctrl checking is done in this block.

Decomposition:
- Shared package alu_pkg:
  - ALU op-code localparams: ADD=0, SUB=1, XOR=2, SLL=3, SLT=4, SRL=5, SRA=6, AND=7, OR=8, BEQ=9, BNE=10, BLT=11, BGE=12, SLTU=13, BLTU=14, BGEU=15.
  - DATA_W=32 and CTRL_W=6 constants, used by both the ALU and this block.
- One sub-module, rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, rr_last.
  - Output: one-hot grant plus encoded index.
  - Purely combinational.

Test Plan:
- Reset, then req0 only, ADD 5+7 -> req_ready[0]=1 at N, rsp_valid=01 with rsp_data=12 at N+2, busy low at N+3.
- Both valid every cycle, rsp_ready=11:
  - req0 = XOR 0xF0F0_F0F0 ^ 0x0F0F_0F0F, req1 = OR 0x1 | 0x2.
  - Required: grants alternate 0,1,0,1 after reset.
  - Required: responses 0xFFFF_FFFF then 0x3, one per cycle, ids alternating.
- Backpressure:
  - rsp_ready=00 for 5 cycles with 3 requests queued.
  - Required: exactly 2 accepts, then req_ready=00; rsp_data stable.
  - Release rsp_ready -> remaining responses in order, no loss or duplication.
- Flush with S1 and S2 both full:
  - Required: rsp_valid=00 the next cycle and no late response for the flushed ids.
  - Required: next request completes normally in 2 cycles.
- Reset asserted mid-stream (rsp_valid=10 pending):
  - Required: all outputs return to reset values after the edge.
  - Required: first post-reset grant goes to req0 even if req1 was last granted.
- NREQ=3, all valid, rsp_ready all high -> grant order 0,1,2,0 with correct rsp id per result.
